input_debounce: RTL and testbench
=================================

INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16: consecutive mismatching cycles needed to accept a new level; legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of each per-channel counter; CNT_W SHALL be wide enough to hold DEB_CYCLES.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port raw_in, input, 4 bits: asynchronous board switches/buttons, one bit per channel.
REQ-006 Port stable_out, output, 4 bits: debounced levels; drives the peripheral system's INPUTSP1 directly.
REQ-007 Port rise_pulse, output, 4 bits: one-cycle strobe per channel when stable_out goes 0->1.
REQ-008 Port fall_pulse, output, 4 bits: one-cycle strobe per channel when stable_out goes 1->0.
REQ-009 Port any_change, output, 1 bit: OR of all rise_pulse and fall_pulse bits, registered in the same cycle as the pulses.

Function
REQ-010 Each channel SHALL pass raw_in[i] through a two-flop synchronizer (s1, then s2) before any other use.
REQ-011 Each channel SHALL hold a counter cnt[i] and a registered level stable_out[i].
REQ-012 At each edge where s2 != stable_out[i] and cnt[i] < DEB_CYCLES-1, the counter SHALL increment by 1.
REQ-013 At each edge where s2 == stable_out[i], the counter SHALL clear to 0; a glitch shorter than DEB_CYCLES cycles therefore never changes stable_out.
REQ-014 At the edge where s2 != stable_out[i] and cnt[i] == DEB_CYCLES-1, all three updates SHALL happen together:
  - stable_out[i] <= s2
  - cnt[i] <= 0
  - the matching rise_pulse[i] or fall_pulse[i] <= 1 for exactly that one cycle
REQ-015 Latency: take the first edge that samples a new raw level as edge 1. If the level holds, stable_out SHALL change at edge DEB_CYCLES+2, never earlier or later.
REQ-016 Channels SHALL be fully independent; several channels MAY pulse in the same cycle.
REQ-017 Pulses SHALL be zero in every cycle without an accepted transition; rise_pulse[i] and fall_pulse[i] SHALL never both be 1.
REQ-018 The counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-019 A raw toggle that reverses exactly at count DEB_CYCLES-1 SHALL clear the counter without accepting the transition.
REQ-020 Outputs SHALL be purely registered, with no combinational path from raw_in to any output.

Reset
REQ-021 While rst=1 at an edge, the following SHALL all load 0:
  - s1 and s2
  - cnt
  - stable_out
  - rise_pulse, fall_pulse and any_change
REQ-022 rst asserted mid-count SHALL discard the partial count; after release, debouncing SHALL restart from cnt=0, stable_out=0.
REQ-023 If raw_in=1 while rst=1, no rise_pulse SHALL occur during reset; the first rise_pulse SHALL occur at edge DEB_CYCLES+2 after rst deasserts.

Structure
REQ-024 The shared peripheral package/header SHALL hold:
  - NUM_IN_CH=4
  - the default DEB_CYCLES value
  - the peripheral input width, shared with PeriphSystem's INPUTSP1 width
REQ-025 One sub-module, debounce_channel, SHALL implement the synchronizer, counter, level and pulses for one bit.
REQ-026 input_debounce SHALL instantiate debounce_channel NUM_IN_CH times and register any_change.

Verification (DEB_CYCLES=4 in simulation)
REQ-027 Scenario "clean press": raw_in 0000->0001 held -> stable_out[0]=1 and rise_pulse=0001 for one cycle at edge 6; no other bits change.
REQ-028 Scenario "glitch": raw_in[1]=1 for 3 cycles, then 0 -> stable_out, rise_pulse and fall_pulse stay 0000 throughout.
REQ-029 Scenario "release": stable_out=0001, raw_in -> 0000 held -> fall_pulse=0001 for one cycle and stable_out=0000 at edge 6; any_change=1 in that cycle only.
REQ-030 Scenario "simultaneous": raw_in 0000->1010 held -> rise_pulse=1010 and stable_out=1010 in the same cycle, edge 6.
REQ-031 Scenario "bounce": raw_in[2] pattern 1,1,1,0,1,1,1,1 -> the counter resets at the 0, and stable_out[2]=1 occurs exactly 6 edges after the final rising sample.
REQ-032 Scenario "reset mid-count": raw_in=0100 for 3 cycles, rst=1 for 1 cycle, raw_in held -> all outputs 0 at the reset edge; stable_out=0100 at edge 6 after release.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared peripheral constants for the board-input debouncer.
// The input width here is the same width the peripheral system uses for INPUTSP1.
package input_debounce_pkg;
    localparam int NUM_IN_CH          = 4;
    localparam int DEB_CYCLES_DEFAULT = 16;
    localparam int INPUTSP1_W         = NUM_IN_CH;
endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: two-flop synchronizer, mismatch counter, accepted level
// and one-cycle rise/fall strobes.
module debounce_channel #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = (s2 != stable);
    // Derived only from registers; the parent registers it alongside the pulses.
    assign accept   = mismatch && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
                rise   <= s2;
                fall   <= ~s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/input_debounce.sv
// Debounces the board switch/button inputs, one independent channel per bit,
// and flags any accepted transition on any_change in the same cycle as the strobes.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN_CH-1:0]  raw_in,
    output logic [INPUTSP1_W-1:0] stable_out,
    output logic [NUM_IN_CH-1:0]  rise_pulse,
    output logic [NUM_IN_CH-1:0]  fall_pulse,
    output logic                  any_change
);
    logic [NUM_IN_CH-1:0] accept;

    for (genvar i = 0; i < NUM_IN_CH; i++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_in[i]),
            .stable (stable_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i]),
            .accept (accept[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end
endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEB_CYCLES=4: vector table plus
// hand sequences for bounce, reset mid-count and raw-high-during-reset.
module tb_input_debounce;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'b0000;
    logic [3:0] stable_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_change;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] stable;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];

    input_debounce #(
        .DEB_CYCLES (DEB),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // drivers
    task automatic step(input logic r, input logic [3:0] raw);
        rst    = r;
        raw_in = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] raw, input logic [3:0] s,
                       input logic [3:0] ri, input logic [3:0] f, input logic a);
        vecs.push_back({r, raw, s, ri, f, a});
    endtask

    // Hold raw for 8 edges from a settled state: level and strobe change at edge 6.
    task automatic add_hold(input logic [3:0] raw, input logic [3:0] old_s, input logic [3:0] new_s,
                            input logic [3:0] ri, input logic [3:0] f);
        for (int e = 1; e <= 8; e++) begin
            if (e < DEB + 2)       add(1'b0, raw, old_s, 4'b0, 4'b0, 1'b0);
            else if (e == DEB + 2) add(1'b0, raw, new_s, ri, f, 1'b1);
            else                   add(1'b0, raw, new_s, 4'b0, 4'b0, 1'b0);
        end
    endtask

    task automatic settle_reset();
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        check("reset_outputs", {stable_out, rise_pulse, fall_pulse, any_change}, 13'd0);
    endtask

    initial begin
        int          n;
        logic        pat[8];
        logic [12:0] exp_v;

        // reset rows
        add(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0);
        add(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0);
        // clean press, then release
        add_hold(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add_hold(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        // glitch on channel 1: three high samples never reach acceptance
        for (int e = 0; e < 3; e++) add(1'b0, 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0);
        for (int e = 0; e < 6; e++) add(1'b0, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0);
        // simultaneous press and release on channels 3 and 1
        add_hold(4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000);
        add_hold(4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
        // mixed: 0101 rises while nothing else moves
        add_hold(4'b0101, 4'b0000, 4'b0101, 4'b0101, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back({vecs[i].stable, vecs[i].rise, vecs[i].fall, vecs[i].any});
            step(vecs[i].rst, vecs[i].raw);
            exp_v = exp_q.pop_front();
            checks++;
            if ({stable_out, rise_pulse, fall_pulse, any_change} !== exp_v) begin
                errors++;
                $display("FAIL vec[%0d]: got s=%b r=%b f=%b a=%b expected s=%b r=%b f=%b a=%b",
                         i, stable_out, rise_pulse, fall_pulse, any_change,
                         exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end

        // bounce on channel 2: the 0 arrives exactly at full count and clears it
        settle_reset();
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, {1'b0, pat[i], 2'b00});
            check("bounce_hold_low", {stable_out, rise_pulse}, 8'h00);
        end
        // edge 8 is the 4th edge counted from the final rising sample (edge 5)
        n = 4;
        while (n < 20) begin
            step(1'b0, 4'b0100);
            n++;
            if (stable_out[2]) break;
        end
        check("bounce_accept_edge", n, 6);
        check("bounce_rise", {stable_out, rise_pulse, any_change}, {4'b0100, 4'b0100, 1'b1});

        // reset mid-count
        settle_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        check("midcount_reset_outputs", {stable_out, rise_pulse, fall_pulse, any_change}, 13'd0);
        n = 0;
        while (n < 20) begin
            step(1'b0, 4'b0100);
            n++;
            if (stable_out != 4'b0000) break;
        end
        check("midcount_restart_edge", n, 6);
        check("midcount_level", stable_out, 4'b0100);

        // raw high while reset held: no strobes until counted after release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111);
            check("raw_high_in_reset", {stable_out, rise_pulse, any_change}, 9'd0);
        end
        n = 0;
        while (n < 20) begin
            step(1'b0, 4'b1111);
            n++;
            if (rise_pulse != 4'b0000) break;
        end
        check("first_rise_edge", n, 6);
        check("first_rise_value", {stable_out, rise_pulse, any_change}, {4'b1111, 4'b1111, 1'b1});
        step(1'b0, 4'b1111);
        check("rise_one_cycle", {rise_pulse, fall_pulse, any_change}, 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
